data_cache_writeback_unit: RTL and testbench
============================================

Name: data_cache_writeback_unit

Overview:
- Downstream consumer of a data cache way's read-only port 1: on a victim-eviction request it reads the status and tag of one cache line.
- If the line is valid and dirty, it reads every word of the block, one chip at a time, and streams the words to the memory interface over a valid/ready handshake.
- Sits between the data cache controller (which issues start and later clears the dirty bit using written_o) and the external memory / store path.

Parameters:
- ADDR_WIDTH, 8: cache line index width; drives port1_address_o.
- TAG_SIZE, 20: tag width.
- BLOCK_WORDS, 4: 32-bit words per cache block (power of 2, at least 2).
- CHIP_ADDR, $clog2(BLOCK_WORDS): word/chip select width.
- PHYS_ADDR, 32: memory address width; must equal TAG_SIZE + ADDR_WIDTH + CHIP_ADDR + 2.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- writeback_start_i  in  1  eviction request, sampled only in IDLE
- writeback_index_i  in  ADDR_WIDTH  victim line index, captured with start
- writeback_busy_o  out  1  high in every state except IDLE
- writeback_done_o  out  1  one-cycle completion pulse
- writeback_written_o  out  1  valid with done; 1 = line was transferred to memory
- port1_enable_o  out  4  {valid, dirty, tag, data} field enables to the way
- port1_chip_select_o  out  CHIP_ADDR  word select to the way
- port1_address_o  out  ADDR_WIDTH  line index to the way
- port1_read_o  out  1  read strobe to the way
- port1_valid_i  in  1  valid bit from the way
- port1_dirty_i  in  1  dirty bit from the way
- port1_tag_i  in  TAG_SIZE  tag from the way
- port1_word_i  in  32  data word from the way
- mem_valid_o  out  1  write beat valid
- mem_ready_i  in  1  memory accepts the beat
- mem_address_o  out  PHYS_ADDR  byte address of the beat
- mem_data_o  out  32  beat data
- mem_last_o  out  1  marks the final beat of the block

Behaviour:
- Way read timing: the way has synchronous read. Address and read strobe are sampled at edge k; data is valid during the cycle after edge k and is not guaranteed to persist.
- FSM states: IDLE, TAG_READ, TAG_CHECK, WORD_READ, WORD_LATCH, WORD_SEND, DONE.
- IDLE: on writeback_start_i, capture index_q and go to TAG_READ. Start is ignored in every other state.
- TAG_READ: port1_read_o=1, port1_enable_o=4'b1110, port1_address_o=index_q. Go to TAG_CHECK.
- TAG_CHECK:
  - Capture tag_q from port1_tag_i.
  - If port1_valid_i & port1_dirty_i: clear the word counter cnt and go to WORD_READ.
  - Otherwise go to DONE with written=0.
- WORD_READ: port1_read_o=1, port1_enable_o=4'b0001, chip_select=cnt. Go to WORD_LATCH.
- WORD_LATCH: register port1_word_i into data_q. Go to WORD_SEND.
- WORD_SEND:
  - mem_valid_o=1, mem_data_o=data_q, mem_address_o={tag_q, index_q, cnt, 2'b00}.
  - mem_last_o = (cnt == BLOCK_WORDS-1).
  - On mem_valid_o & mem_ready_i: if last, go to DONE with written=1; else cnt+1, go to WORD_READ.
  - Without ready, hold every mem_* output stable. valid is never withdrawn before the handshake.
- DONE: writeback_done_o=1 and writeback_written_o=written for exactly one cycle. Go to IDLE.
- Outside their active states, port1_read_o, port1_enable_o and mem_valid_o are 0. Address, chip-select and data outputs hold their last value.
- cnt is CHIP_ADDR bits wide and is compared explicitly against the last word; it never wraps to 0 inside a transfer.
- Latency, start sampled at edge T, memory always ready:
  - TAG_READ at T+1, TAG_CHECK at T+2.
  - Each word takes 3 cycles (word n is sent at T+5+3n).
  - Dirty line, BLOCK_WORDS=4: done at T+15. Clean or invalid line: done at T+3.
  - Each cycle of mem_ready_i low extends the transfer by one cycle.
- Reset (asynchronous, rst_n_i low, any state, including mid-transfer):
  - FSM to IDLE immediately; cnt, index_q, tag_q, data_q and written cleared.
  - All outputs 0, including mem_valid_o and writeback_busy_o.
  - A partially sent block is abandoned; no done pulse is produced.
- Start asserted in the DONE cycle is ignored; it is accepted only when re-sampled in IDLE.

Test Plan:
- Reset during WORD_SEND with mem_valid_o=1 -> mem_valid_o, busy and done drop to 0 asynchronously; after release, a new start runs normally from TAG_READ.
- Dirty line, index 0x2A, tag 0x12345, words {A0,A1,A2,A3}, ready tied high:
  - beats at addresses 0x123452A0, 0x123452A4, 0x123452A8, 0x123452AC carry data A0..A3;
  - mem_last_o is high on beat 3 only;
  - done and written are 1 at T+15.
- Valid but clean line (dirty=0) -> no mem_valid_o; done=1 and written=0 at T+3. An invalid line gives the same result.
- Dirty line with mem_ready_i low for 5 cycles on beat 1 -> mem_address_o and mem_data_o stay constant across those cycles; done moves to T+20.
- Start pulsed while busy, and again in the DONE cycle -> both ignored; exactly one done pulse; the next start in IDLE is accepted.
- BLOCK_WORDS=8 configuration -> 8 beats with cnt 0..7 and no wrap; mem_last_o is high on cnt=7 only.

Source files
------------

// File: rtl/data_cache_writeback_unit.sv
// -----------------------------------------------------------------------------
// data_cache_writeback_unit
//
// Purpose:
//   Evicts one cache line on request. The unit reads the line's valid, dirty and
//   tag fields through read-only port 1 of a cache way. If the line is both
//   valid and dirty, it reads each data word of the block in turn and streams it
//   to memory over a valid/ready handshake. Once the block has been sent, or
//   nothing needed sending, it reports completion with a single-cycle done pulse.
//
// Ports:
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   writeback_start_i      eviction request, accepted only while idle
//   writeback_index_i      victim line index, captured with the request
//   writeback_busy_o       high whenever the unit is not idle
//   writeback_done_o       one-cycle completion pulse
//   writeback_written_o    qualifies done: 1 = the block went to memory
//   port1_*                read-only way port (synchronous read, 1-cycle latency)
//   mem_*                  write-beat stream to memory (valid/ready, last marker)
// -----------------------------------------------------------------------------
module data_cache_writeback_unit #(
  parameter int ADDR_WIDTH  = 8,
  parameter int TAG_SIZE    = 20,
  parameter int BLOCK_WORDS = 4,
  parameter int CHIP_ADDR   = $clog2(BLOCK_WORDS),
  parameter int PHYS_ADDR   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  writeback_start_i,
  input  logic [ADDR_WIDTH-1:0] writeback_index_i,
  output logic                  writeback_busy_o,
  output logic                  writeback_done_o,
  output logic                  writeback_written_o,
  output logic [3:0]            port1_enable_o,
  output logic [CHIP_ADDR-1:0]  port1_chip_select_o,
  output logic [ADDR_WIDTH-1:0] port1_address_o,
  output logic                  port1_read_o,
  input  logic                  port1_valid_i,
  input  logic                  port1_dirty_i,
  input  logic [TAG_SIZE-1:0]   port1_tag_i,
  input  logic [31:0]           port1_word_i,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [PHYS_ADDR-1:0]  mem_address_o,
  output logic [31:0]           mem_data_o,
  output logic                  mem_last_o
);

  typedef enum logic [2:0] {
    IDLE,
    TAG_READ,
    TAG_CHECK,
    WORD_READ,
    WORD_LATCH,
    WORD_SEND,
    DONE
  } state_t;

  // Field enables driven to the way: {valid, dirty, tag, data}.
  localparam logic [3:0] EN_STATUS = 4'b1110;
  localparam logic [3:0] EN_DATA   = 4'b0001;

  localparam logic [CHIP_ADDR-1:0] LAST_WORD = CHIP_ADDR'(BLOCK_WORDS - 1);

  state_t                 state_reg,   state_next;
  logic [ADDR_WIDTH-1:0]  index_reg,   index_next;
  logic [TAG_SIZE-1:0]    tag_reg,     tag_next;
  logic [CHIP_ADDR-1:0]   cnt_reg,     cnt_next;
  logic [31:0]            data_reg,    data_next;
  logic                   written_reg, written_next;

  logic last_word;

  // The counter is compared against the final word explicitly, so it stops at
  // BLOCK_WORDS-1 and never relies on wrapping to end the block.
  assign last_word = (cnt_reg == LAST_WORD);

  // Address, chip-select and data outputs come straight from the captured
  // registers, so they hold their last value outside the active states and
  // are all zero after reset.
  assign port1_address_o     = index_reg;
  assign port1_chip_select_o = cnt_reg;
  assign mem_address_o       = {tag_reg, index_reg, cnt_reg, 2'b00};
  assign mem_data_o          = data_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg   <= IDLE;
      index_reg   <= '0;
      tag_reg     <= '0;
      cnt_reg     <= '0;
      data_reg    <= '0;
      written_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      index_reg   <= index_next;
      tag_reg     <= tag_next;
      cnt_reg     <= cnt_next;
      data_reg    <= data_next;
      written_reg <= written_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    index_next          = index_reg;
    tag_next            = tag_reg;
    cnt_next            = cnt_reg;
    data_next           = data_reg;
    written_next        = written_reg;
    port1_read_o        = 1'b0;
    port1_enable_o      = 4'b0000;
    mem_valid_o         = 1'b0;
    mem_last_o          = 1'b0;
    writeback_done_o    = 1'b0;
    writeback_written_o = 1'b0;
    writeback_busy_o    = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (writeback_start_i) begin
          index_next   = writeback_index_i;
          written_next = 1'b0;
          state_next   = TAG_READ;
        end
      end

      TAG_READ: begin
        port1_read_o   = 1'b1;
        port1_enable_o = EN_STATUS;
        state_next     = TAG_CHECK;
      end

      // Way data is only guaranteed during the cycle after the read edge, so
      // the decision and the tag capture both happen here.
      TAG_CHECK: begin
        tag_next = port1_tag_i;
        if (port1_valid_i && port1_dirty_i) begin
          cnt_next   = '0;
          state_next = WORD_READ;
        end else begin
          written_next = 1'b0;
          state_next   = DONE;
        end
      end

      WORD_READ: begin
        port1_read_o   = 1'b1;
        port1_enable_o = EN_DATA;
        state_next     = WORD_LATCH;
      end

      // The word is registered so the beat stays stable however long the
      // memory holds off ready.
      WORD_LATCH: begin
        data_next  = port1_word_i;
        state_next = WORD_SEND;
      end

      WORD_SEND: begin
        mem_valid_o = 1'b1;
        mem_last_o  = last_word;
        if (mem_ready_i) begin
          if (last_word) begin
            written_next = 1'b1;
            state_next   = DONE;
          end else begin
            cnt_next   = cnt_reg + CHIP_ADDR'(1);
            state_next = WORD_READ;
          end
        end
      end

      DONE: begin
        writeback_done_o    = 1'b1;
        writeback_written_o = written_reg;
        state_next          = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_cache_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_data_cache_writeback_unit
//
// Drives two instances in lock-step: a 4-word block (20-bit tag) and an 8-word
// block (19-bit tag). Each instance is attached to a behavioural cache way with
// synchronous read. While the way is not being read, its outputs carry random
// values. A timeline model predicts busy, done, written and every memory beat
// from the line contents and the cycle on which start was accepted. On
// selected 4-word transactions, literal latencies, addresses and data pin the
// model itself.
// -----------------------------------------------------------------------------
module tb_data_cache_writeback_unit;

  localparam int NU = 2;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       start     = 1'b0;
  logic [7:0] start_idx = 8'h00;
  logic       ready     = 1'b1;
  int         edge_count = 0;
  int         lit_id     = 0;
  int         errors     = 0;
  int         checks     = 0;

  always #5 clk = ~clk;

  always @(posedge clk) edge_count <= edge_count + 1;

  // Cache way contents, per instance.
  logic        st_valid [NU][256];
  logic        st_dirty [NU][256];
  logic [19:0] st_tag   [NU][256];
  logic [31:0] st_word  [NU][256][8];

  // Observed DUT outputs, gathered from the generate blocks.
  logic [NU-1:0]       o_busy, o_done, o_written, o_mvalid, o_mlast, o_any;
  logic [NU-1:0][31:0] o_maddr, o_mdata;

  for (genvar gi = 0; gi < NU; gi++) begin : g_dut
    localparam int BW = (gi == 0) ? 4 : 8;
    localparam int CA = $clog2(BW);
    localparam int TS = (gi == 0) ? 20 : 19;

    logic          busy, done, written, rd, mvalid, mlast;
    logic [3:0]    en;
    logic [CA-1:0] cs;
    logic [7:0]    addr;
    logic [31:0]   maddr, mdata;
    logic          w_valid, w_dirty;
    logic [TS-1:0] w_tag;
    logic [31:0]   w_word;
    int            cs_i;

    data_cache_writeback_unit #(
      .ADDR_WIDTH (8),
      .TAG_SIZE   (TS),
      .BLOCK_WORDS(BW),
      .CHIP_ADDR  (CA),
      .PHYS_ADDR  (32)
    ) u_dut (
      .clk_i              (clk),
      .rst_n_i            (rst_n),
      .writeback_start_i  (start),
      .writeback_index_i  (start_idx),
      .writeback_busy_o   (busy),
      .writeback_done_o   (done),
      .writeback_written_o(written),
      .port1_enable_o     (en),
      .port1_chip_select_o(cs),
      .port1_address_o    (addr),
      .port1_read_o       (rd),
      .port1_valid_i      (w_valid),
      .port1_dirty_i      (w_dirty),
      .port1_tag_i        (w_tag),
      .port1_word_i       (w_word),
      .mem_valid_o        (mvalid),
      .mem_ready_i        (ready),
      .mem_address_o      (maddr),
      .mem_data_o         (mdata),
      .mem_last_o         (mlast)
    );

    assign cs_i = int'(cs);

    // Synchronous-read way: only enabled fields are returned, and only for
    // the cycle after a read edge; everything else is noise.
    always @(posedge clk) begin
      if (rd) begin
        w_valid <= en[3] ? st_valid[gi][addr] : 1'($urandom);
        w_dirty <= en[2] ? st_dirty[gi][addr] : 1'($urandom);
        w_tag   <= en[1] ? st_tag[gi][addr][TS-1:0] : TS'($urandom);
        w_word  <= en[0] ? st_word[gi][addr][cs_i] : $urandom;
      end else begin
        w_valid <= 1'($urandom);
        w_dirty <= 1'($urandom);
        w_tag   <= TS'($urandom);
        w_word  <= $urandom;
      end
    end

    assign o_busy[gi]    = busy;
    assign o_done[gi]    = done;
    assign o_written[gi] = written;
    assign o_mvalid[gi]  = mvalid;
    assign o_mlast[gi]   = mlast;
    assign o_maddr[gi]   = maddr;
    assign o_mdata[gi]   = mdata;
    assign o_any[gi]     = |{busy, done, written, rd, en, cs, addr, mvalid, mlast, maddr, mdata};
  end

  // Hand-computed expectations for the pinned 4-word transactions
  // (lit 1: dirty, ready high; 2: clean; 3: invalid; 4: dirty, 5-cycle stall).
  localparam logic [31:0] LIT_ADDR [4] = '{32'h123452A0, 32'h123452A4, 32'h123452A8, 32'h123452AC};
  localparam logic [31:0] LIT_DATA [4] = '{32'h000000A0, 32'h000000A1, 32'h000000A2, 32'h000000A3};
  localparam int          LIT_LAT  [5] = '{0, 15, 3, 3, 20};
  localparam int          LIT_WR   [5] = '{0, 1, 0, 0, 1};

  task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d edge %0d: got 0x%08h expected 0x%08h", name, u, edge_count + 1, act, exp);
    end
  endtask

  // Model state per instance: a transaction accepted at edge t finishes at
  // done_edge; beat n of a dirty line completes at next_hs, and every cycle
  // without ready pushes both the beat and the completion one cycle later.
  logic        m_active [NU];
  logic        m_dirty  [NU];
  logic [7:0]  m_idx    [NU];
  logic [19:0] m_tag    [NU];
  int          m_t [NU], m_done_edge [NU], m_next_hs [NU], m_beat [NU], m_words [NU], m_lit [NU];

  initial begin
    int          e, ca, lid;
    logic        exp_busy, exp_done, exp_valid;
    logic [31:0] ea, ed;
    forever begin
      @(negedge clk);
      e = edge_count + 1;
      for (int u = 0; u < NU; u++) begin
        if (!rst_n) begin
          chk("reset_outputs_any", u, 32'(o_any[u]), 32'd0);
          m_active[u] = 1'b0;
        end else begin
          if (m_active[u] && e > m_done_edge[u]) m_active[u] = 1'b0;
          exp_busy  = m_active[u] && (e > m_t[u]);
          exp_done  = m_active[u] && (e == m_done_edge[u]);
          exp_valid = m_active[u] && m_dirty[u] && (m_beat[u] < m_words[u]) && (e >= m_next_hs[u]);
          chk("busy", u, 32'(o_busy[u]), 32'(exp_busy));
          chk("done", u, 32'(o_done[u]), 32'(exp_done));
          chk("mem_valid", u, 32'(o_mvalid[u]), 32'(exp_valid));
          lid = m_lit[u];
          if (exp_done) begin
            chk("written", u, 32'(o_written[u]), 32'(m_dirty[u]));
            if (lid != 0) begin
              chk("lit_latency", u, 32'(e - m_t[u]), 32'(LIT_LAT[lid]));
              chk("lit_written", u, 32'(o_written[u]), 32'(LIT_WR[lid]));
            end
          end
          if (exp_valid && o_mvalid[u]) begin
            ca = (u == 0) ? 2 : 3;
            ea = (32'(m_tag[u]) << (10 + ca)) | (32'(m_idx[u]) << (ca + 2)) | (32'(m_beat[u]) << 2);
            ed = st_word[u][m_idx[u]][m_beat[u]];
            chk("mem_address", u, o_maddr[u], ea);
            chk("mem_data", u, o_mdata[u], ed);
            chk("mem_last", u, 32'(o_mlast[u]), 32'(m_beat[u] == m_words[u] - 1));
            if (lid == 1 || lid == 4) begin
              chk("lit_address", u, o_maddr[u], LIT_ADDR[m_beat[u]]);
              chk("lit_data", u, o_mdata[u], LIT_DATA[m_beat[u]]);
            end
            if (ready) begin
              m_beat[u]    = m_beat[u] + 1;
              m_next_hs[u] = m_next_hs[u] + 3;
            end else begin
              m_next_hs[u]   = m_next_hs[u] + 1;
              m_done_edge[u] = m_done_edge[u] + 1;
            end
          end
          if (start && !m_active[u]) begin
            m_active[u]    = 1'b1;
            m_t[u]         = e;
            m_idx[u]       = start_idx;
            m_tag[u]       = st_tag[u][start_idx];
            m_dirty[u]     = st_valid[u][start_idx] && st_dirty[u][start_idx];
            m_words[u]     = (u == 0) ? 4 : 8;
            m_beat[u]      = 0;
            m_next_hs[u]   = e + 5;
            m_done_edge[u] = m_dirty[u] ? (e + 3 + 3 * m_words[u]) : (e + 3);
            m_lit[u]       = (u == 0) ? lit_id : 0;
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] idx, input int id, input int hold);
    lit_id    = id;
    start_idx = idx;
    start     = 1'b1;
    cyc(hold);
    start     = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      for (int i = 0; i < 256; i++) begin
        st_valid[u][i] = 1'b0;
        st_dirty[u][i] = 1'b0;
        st_tag[u][i]   = 20'h0;
        for (int w = 0; w < 8; w++) st_word[u][i][w] = $urandom;
      end
      st_valid[u][8'h2A] = 1'b1;
      st_dirty[u][8'h2A] = 1'b1;
      st_tag[u][8'h2A]   = 20'h12345;
      for (int w = 0; w < 8; w++) st_word[u][8'h2A][w] = 32'h000000A0 + 32'(w);
      st_valid[u][8'h11] = 1'b1;
      st_dirty[u][8'h11] = 1'b0;
      st_tag[u][8'h11]   = 20'h0BEEF;
      st_valid[u][8'h33] = 1'b0;
      st_dirty[u][8'h33] = 1'b1;
      st_valid[u][8'h5C] = 1'b1;
      st_dirty[u][8'h5C] = 1'b1;
      st_tag[u][8'h5C]   = (u == 0) ? 20'hABCDE : 20'h2BCDE;
    end

    #1 rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Dirty line, memory always ready.
    pulse_start(8'h2A, 1, 1);
    cyc(30);

    // Clean line with start held through busy and DONE, then an invalid line.
    pulse_start(8'h11, 2, 4);
    cyc(2);
    pulse_start(8'h33, 3, 1);
    cyc(6);

    // Dirty line, ready low for five cycles while beat 1 is offered.
    pulse_start(8'h2A, 4, 1);
    cyc(7);
    ready = 1'b0;
    cyc(5);
    ready = 1'b1;
    cyc(35);

    // Dirty line with irregular ready.
    pulse_start(8'h5C, 0, 1);
    for (int i = 0; i < 40; i++) begin
      ready = 1'($urandom_range(0, 1));
      cyc(1);
    end
    ready = 1'b1;
    cyc(40);

    // Reset while a beat is being offered, then a normal transfer.
    ready = 1'b0;
    pulse_start(8'h5C, 0, 1);
    cyc(4);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    ready = 1'b1;
    cyc(2);
    pulse_start(8'h2A, 1, 1);
    cyc(32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
